uart_emitter: RTL and testbench
===============================

Name: uart_emitter

Overview:
Parametrised UART transmitter with an internal FIFO. It fills the missing UART emitter slot in the UART top-level and drives the serial TX line from the core's uart write port. Frame format (data bits, parity, stop bits), bit period and buffering depth are compile-time parameters. Back-to-back frames are sent with zero idle gap.

Parameters:
CLK_DIV, 16, clock cycles per serial bit; legal range is >=2.
DATA_BITS, 8, data bits per frame; legal range is 5..9.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, number of stop bits; 1 or 2.
FIFO_DEPTH, 4, FIFO entries; must be a power of two, >=2.

Ports:
CLK  input  1  clock
RST  input  1  reset; synchronous, active-high
wr_arg  input  DATA_BITS+1  {valid, data}; the MSB is valid; same opt-byte convention as the core's uart write port
wr_ready  output  1  slot available; a transfer happens when valid && wr_ready in the same cycle
tx  output  1  serial line; idles high; registered
busy  output  1  a frame is in flight, or the FIFO is non-empty
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Illegal parameters must be rejected by an elaboration-time assertion.
- Reset values: tx=1, wr_ready=0 while RST is high, busy=0, fifo_level=0, FSM=IDLE, all counters=0.
- wr_ready = !RST && (fifo_level != FIFO_DEPTH), computed from registered state only.
- Push when full: no transfer occurs. The producer must hold valid and data stable until the handshake.
- Simultaneous push and pop: occupancy is unchanged.
- FIFO: circular buffer with wrapping read and write pointers plus a count. Data written in cycle N is poppable in cycle N+1; there is no fall-through.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1. If the FIFO is non-empty: pop, load the shift register, compute parity, set tx=0, go to START.
- Parity bit: XOR of the data bits for even parity; inverted XOR for odd parity.
- Bit timer counts 0..CLK_DIV-1. A bit ends when the timer reaches CLK_DIV-1; the timer then reloads to 0.
- START to DATA after one bit. tx carries data LSB first, one bit each bit period.
- DATA has a bit index 0..DATA_BITS-1. After the last data bit: go to PARITY if PARITY != 0, else go to STOP.
- PARITY: tx=parity bit for one bit period, then STOP.
- STOP: tx=1 for STOP_BITS bit periods. On the final cycle of the last stop bit:
  - FIFO non-empty: pop and load the next frame, so the next start bit begins the very next cycle (zero gap).
  - FIFO empty: go to IDLE.
- Latency: a byte accepted into an empty, idle block in cycle N is popped in cycle N+1; tx goes low from cycle N+2.
- Frame length: exactly (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLK_DIV cycles.
- busy = (state != IDLE) || (fifo_level != 0).
- RST asserted mid-frame: on the next edge tx=1, the frame is aborted, the FIFO is emptied, the FSM goes to IDLE. No partial frame resumes after reset.

Decomposition:
- uart_pkg holds:
  - the parity_e enum (PAR_NONE, PAR_ODD, PAR_EVEN);
  - the state_e FSM enum;
  - the function frame_bits(data_bits, parity, stop_bits).
- One sub-module, uart_fifo: a synchronous FIFO parametrised by WIDTH and DEPTH, with push, pop, dout, level, full and empty.
- The FSM, bit timer and shift register live in uart_emitter.

Test Plan:
All scenarios use CLK_DIV=4, DATA_BITS=8, STOP_BITS=1, FIFO_DEPTH=4 unless stated.
- Single byte: push 0x55 in cycle 10 with PARITY=0 -> tx low for cycles 12-15; bits 1,0,1,0,1,0,1,0 for 4 cycles each (cycles 16-47); high for 48-51; busy falls at cycle 52; the frame is 40 cycles.
- Parity, one case per mode:
  - PARITY=1, push 0x03 -> parity bit 1 during cycles 48-51, stop bit 52-55.
  - PARITY=2, push 0x03 -> parity bit 0.
  - PARITY=2, push 0x07 -> parity bit 1.
- Fill and backpressure: hold valid from cycle 0 with bytes A..F.
  - A pops in cycle 1.
  - A..E are accepted in cycles 0-4; fifo_level=4 and wr_ready=0 from cycle 5.
  - wr_ready returns 1 in the cycle after A's final stop cycle (cycle 42); F is accepted then.
- Back-to-back: frames A and B are contiguous: the last stop cycle of A is followed immediately by B's start bit, with no idle-high cycle. Total span for A..F is 6*40 cycles from the first start bit.
- Reset mid-frame: RST high for 1 cycle during data bit 3 with 2 bytes queued -> tx=1 and fifo_level=0 on the next edge, wr_ready=0 during reset. No further tx transitions until a new push; the next push behaves as in the single-byte case.
- Parameter sweep: DATA_BITS=5, STOP_BITS=2, CLK_DIV=2, push 0x1F -> frame lasts 16 cycles; a reference receiver model decodes 0x1F.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART emitter and its FIFO.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } state_e;

  // Serial bits in one frame: start + data + optional parity + stop.
  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned parity,
                                             input int unsigned stop_bits);
    int unsigned par_bits;
    par_bits = (parity != 0) ? 1 : 0;
    return 1 + data_bits + par_bits + stop_bits;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous circular-buffer FIFO; a pushed word is poppable the following cycle.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign dout_o  = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/uart_emitter.sv
// UART transmitter: buffered write port feeding a frame serialiser with zero inter-frame gap.
module uart_emitter
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [DATA_BITS:0]            wr_arg,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      frame_bits(DATA_BITS, PARITY, STOP_BITS) > 13) begin : g_param_check
    $fatal(1, "uart_emitter: illegal parameter combination");
  end

  localparam int unsigned TW = $clog2(CLK_DIV);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam parity_e     ParMode = parity_e'(PARITY[1:0]);

  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;

  logic                 wr_valid;
  logic [DATA_BITS-1:0] wr_data;
  logic                 fifo_push, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_dout;
  logic                 load;
  logic                 bit_end;
  logic                 par_calc;

  assign wr_valid  = wr_arg[DATA_BITS];
  assign wr_data   = wr_arg[DATA_BITS-1:0];
  assign wr_ready  = !RST && !fifo_full;
  assign fifo_push = wr_valid && wr_ready;

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (fifo_push),
    .din_i   (wr_data),
    .pop_i   (load),
    .dout_o  (fifo_dout),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bit_end  = (timer_q == TW'(CLK_DIV - 1));
  assign par_calc = (ParMode == PAR_ODD) ? ~(^fifo_dout) : ^fifo_dout;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tx_d       = tx_q;
    load       = 1'b0;

    if (state_q != StIdle) begin
      timer_d = bit_end ? '0 : timer_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!fifo_empty) load = 1'b1;
      end
      StStart: begin
        if (bit_end) begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_idx_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_idx_q == BW'(DATA_BITS - 1)) begin
            if (ParMode != PAR_NONE) begin
              tx_d    = parity_q;
              state_d = StParity;
            end else begin
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = StStop;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (stop_cnt_q != 1'(STOP_BITS - 1)) begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end else if (!fifo_empty) begin
            // Chain straight into the next start bit.
            load = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      shift_d  = fifo_dout;
      parity_d = par_calc;
      tx_d     = 1'b0;
      timer_d  = '0;
      state_d  = StStart;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != StIdle) || (fifo_level != '0);

endmodule

// File: tb/tb_uart_emitter.sv
// Directed bench for uart_emitter: framing, parity modes, backpressure, reset abort, 5N2 sweep.
module tb_uart_emitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [8:0] arg0, arg_odd, arg_ev;
  logic [5:0] arg_sw;
  logic       rdy0, rdy_odd, rdy_ev, rdy_sw;
  logic       tx0, tx_odd, tx_ev, tx_sw;
  logic       busy0, busy_odd, busy_ev, busy_sw;
  logic [2:0] lvl0, lvl_odd, lvl_ev, lvl_sw;

  uart_emitter #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
    .CLK(clk), .RST(rst), .wr_arg(arg0), .wr_ready(rdy0), .tx(tx0), .busy(busy0),
    .fifo_level(lvl0)
  );
  uart_emitter #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_odd (
    .CLK(clk), .RST(rst), .wr_arg(arg_odd), .wr_ready(rdy_odd), .tx(tx_odd), .busy(busy_odd),
    .fifo_level(lvl_odd)
  );
  uart_emitter #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_ev (
    .CLK(clk), .RST(rst), .wr_arg(arg_ev), .wr_ready(rdy_ev), .tx(tx_ev), .busy(busy_ev),
    .fifo_level(lvl_ev)
  );
  uart_emitter #(.CLK_DIV(2), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut_sw (
    .CLK(clk), .RST(rst), .wr_arg(arg_sw), .wr_ready(rdy_sw), .tx(tx_sw), .busy(busy_sw),
    .fifo_level(lvl_sw)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line level for frame bit k (0 = start); anything past the frame is idle-high.
  function automatic logic fbit(input logic [8:0] d, input int nb, input bit has_par,
                                input logic pbit, input int k);
    if (k == 0) return 1'b0;
    if (k <= nb) return d[k-1];
    if (has_par && k == nb + 1) return pbit;
    return 1'b1;
  endfunction

  // Push d in the current cycle N into idle u_dut0 and check the whole 8N1 frame.
  task automatic single_byte0(input logic [7:0] d, input string tag);
    arg0 = {1'b1, d};
    #1;
    check_eq({tag, "_rdy"}, 32'(rdy0), 32'd1);
    tick();
    arg0 = '0;
    #1;
    check_eq({tag, "_lvl_n1"}, 32'(lvl0), 32'd1);
    check_eq({tag, "_tx_n1"}, 32'(tx0), 32'd1);
    check_eq({tag, "_busy_n1"}, 32'(busy0), 32'd1);
    for (int c = 2; c <= 41; c++) begin
      tick();
      #1;
      check_eq($sformatf("%s_tx_n%0d", tag, c), 32'(tx0), 32'(fbit({1'b0, d}, 8, 0, 1'b0, (c - 2) / 4)));
      if (c == 2) check_eq({tag, "_lvl_n2"}, 32'(lvl0), 32'd0);
    end
    check_eq({tag, "_busy_last_stop"}, 32'(busy0), 32'd1);
    tick();
    #1;
    check_eq({tag, "_busy_done"}, 32'(busy0), 32'd0);
    check_eq({tag, "_tx_done"}, 32'(tx0), 32'd1);
    check_eq({tag, "_lvl_done"}, 32'(lvl0), 32'd0);
  endtask

  logic [7:0] bytes [6];
  logic [4:0] rx_sw;
  int         acc [6];
  int         idx;
  int         quiet;
  logic       accept;

  initial begin
    bytes = '{8'hA5, 8'h3C, 8'hF0, 8'h01, 8'h80, 8'h6E};
    rst = 1'b1;
    arg0 = '0; arg_odd = '0; arg_ev = '0; arg_sw = '0;
    rx_sw = '0;
    tick();
    #1;
    check_eq("rst_tx", 32'(tx0), 32'd1);
    check_eq("rst_rdy", 32'(rdy0), 32'd0);
    check_eq("rst_busy", 32'(busy0), 32'd0);
    check_eq("rst_lvl", 32'(lvl0), 32'd0);
    check_eq("rst_tx_sw", 32'(tx_sw), 32'd1);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_eq("rdy_after_rst", 32'(rdy0), 32'd1);
    for (int i = 0; i < 10; i++) tick();

    // Single byte 0x55, 8N1.
    single_byte0(8'h55, "single");

    // Odd 0x03, even 0x03 and the 5N2 sweep run side by side.
    arg_odd = {1'b1, 8'h03};
    arg_ev  = {1'b1, 8'h03};
    arg_sw  = {1'b1, 5'h1F};
    tick();
    arg_odd = '0; arg_ev = '0; arg_sw = '0;
    for (int c = 1; c <= 46; c++) begin
      #1;
      check_eq($sformatf("odd03_tx_n%0d", c), 32'(tx_odd),
               32'((c < 2) ? 1'b1 : fbit(9'h003, 8, 1, 1'b1, (c - 2) / 4)));
      check_eq($sformatf("ev03_tx_n%0d", c), 32'(tx_ev),
               32'((c < 2) ? 1'b1 : fbit(9'h003, 8, 1, 1'b0, (c - 2) / 4)));
      check_eq($sformatf("sw_tx_n%0d", c), 32'(tx_sw),
               32'((c < 2) ? 1'b1 : fbit(9'h01F, 5, 0, 1'b0, (c - 2) / 2)));
      if (c >= 2 && ((c - 2) % 2) == 1 && (c - 2) / 2 >= 1 && (c - 2) / 2 <= 5)
        rx_sw[(c - 2) / 2 - 1] = tx_sw;
      if (c == 17) check_eq("sw_busy_last", 32'(busy_sw), 32'd1);
      if (c == 18) check_eq("sw_busy_done", 32'(busy_sw), 32'd0);
      if (c == 45) check_eq("odd_busy_last", 32'(busy_odd), 32'd1);
      if (c == 46) check_eq("odd_busy_done", 32'(busy_odd), 32'd0);
      tick();
    end
    check_eq("sw_rx_data", 32'(rx_sw), 32'h1F);

    // Even parity with odd popcount: parity bit 1.
    arg_ev = {1'b1, 8'h07};
    tick();
    arg_ev = '0;
    for (int c = 1; c <= 46; c++) begin
      #1;
      check_eq($sformatf("ev07_tx_n%0d", c), 32'(tx_ev),
               32'((c < 2) ? 1'b1 : fbit(9'h007, 8, 1, 1'b1, (c - 2) / 4)));
      tick();
    end

    // Fill, backpressure and back-to-back frames; valid held from cycle 0.
    rst = 1'b1;
    #1;
    check_eq("fill_rst_rdy", 32'(rdy0), 32'd0);
    tick();
    rst = 1'b0;
    idx = 0;
    for (int c = 0; c <= 243; c++) begin
      arg0 = (idx < 6) ? {1'b1, bytes[idx]} : 9'h000;
      #1;
      if (c == 2) check_eq("fill_lvl_c2", 32'(lvl0), 32'd1);
      if (c == 5 || c == 41) begin
        check_eq($sformatf("fill_lvl_c%0d", c), 32'(lvl0), 32'd4);
        check_eq($sformatf("fill_rdy_c%0d", c), 32'(rdy0), 32'd0);
      end
      if (c == 42) check_eq("fill_rdy_c42", 32'(rdy0), 32'd1);
      if (c >= 2 && c <= 242)
        check_eq($sformatf("b2b_tx_c%0d", c), 32'(tx0),
                 32'(((c - 2) / 40 < 6) ?
                     fbit({1'b0, bytes[(c - 2) / 40 % 6]}, 8, 0, 1'b0, ((c - 2) % 40) / 4) : 1'b1));
      if (c == 241) check_eq("b2b_busy_last", 32'(busy0), 32'd1);
      if (c == 242) check_eq("b2b_busy_done", 32'(busy0), 32'd0);
      accept = rdy0 && arg0[8];
      tick();
      if (accept) begin
        acc[idx] = c;
        idx++;
      end
    end
    check_eq("fill_accept_count", 32'(idx), 32'd6);
    for (int i = 0; i < 5; i++) check_eq($sformatf("fill_acc_%0d", i), 32'(acc[i]), 32'(i));
    check_eq("fill_acc_F", 32'(acc[5]), 32'd42);

    // Reset during data bit 3 with two bytes still queued.
    for (int c = 0; c < 19; c++) begin
      arg0 = (c < 3) ? {1'b1, 8'hC3} : 9'h000;
      tick();
    end
    arg0 = '0;
    rst = 1'b1;
    #1;
    check_eq("mid_tx_bit3", 32'(tx0), 32'd0);
    check_eq("mid_lvl_queued", 32'(lvl0), 32'd2);
    check_eq("mid_rdy_in_rst", 32'(rdy0), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("mid_tx_after", 32'(tx0), 32'd1);
    check_eq("mid_lvl_after", 32'(lvl0), 32'd0);
    check_eq("mid_busy_after", 32'(busy0), 32'd0);
    quiet = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (tx0 === 1'b1) quiet++;
    end
    check_eq("mid_quiet_cycles", 32'(quiet), 32'd60);
    single_byte0(8'h55, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
